// File: rtl/audio_mixer_dac_pkg.sv
// Shared constants and helpers for the sound-generator output stage.
package audio_mixer_dac_pkg;

  localparam int SAMPLE_WIDTH = 9;
  localparam int SUM_WIDTH    = SAMPLE_WIDTH + 1;
  localparam int MIX_WIDTH    = 11;
  localparam int MODE_PWM     = 0;
  localparam int MODE_DSM     = 1;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  function automatic sample_t gate_sample(input sample_t s, input logic mute);
    if (mute) begin
      return {SAMPLE_WIDTH{1'b0}};
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/audio_mixer_dac_modulator.sv
// 1-bit DAC modulator: pending/active hand-off plus PWM counter or
// first-order delta-sigma accumulator, selected at elaboration time.
module dac_modulator #(
  parameter int OUTPUT_MODE = 0,
  parameter int MIX_WIDTH   = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [MIX_WIDTH-1:0] i_sample,
  input  logic                 i_sample_valid,
  output logic                 o_pwm
);
  import audio_mixer_dac_pkg::*;

  logic [MIX_WIDTH-1:0] pending_r, pending_nxt_s;
  logic [MIX_WIDTH-1:0] active_r,  active_nxt_s;
  logic [MIX_WIDTH-1:0] cnt_r,     cnt_nxt_s;
  logic [MIX_WIDTH:0]   acc_r,     acc_nxt_s;
  logic                 pwm_r,     pwm_nxt_s;

  // Next-state logic for both modulator flavours
  always_comb begin
    pending_nxt_s = pending_r;
    active_nxt_s  = active_r;
    cnt_nxt_s     = cnt_r;
    acc_nxt_s     = acc_r;
    pwm_nxt_s     = pwm_r;
    if (i_sample_valid) begin
      pending_nxt_s = i_sample;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (OUTPUT_MODE == MODE_DSM) begin
      active_nxt_s = pending_r;
      acc_nxt_s    = {1'b0, acc_r[MIX_WIDTH-1:0]} + {1'b0, active_r};
      pwm_nxt_s    = acc_r[MIX_WIDTH];
    end else begin
      cnt_nxt_s = cnt_r + {{(MIX_WIDTH-1){1'b0}}, 1'b1};
      // A value arriving on the wrap cycle waits for the next period
      if (cnt_r == {MIX_WIDTH{1'b1}}) begin
        active_nxt_s = pending_r;
      end else begin
        active_nxt_s = active_r;
      end
      pwm_nxt_s = (cnt_r < active_r);
    end
  end

  // Modulator state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_r <= {MIX_WIDTH{1'b0}};
      active_r  <= {MIX_WIDTH{1'b0}};
      cnt_r     <= {MIX_WIDTH{1'b0}};
      acc_r     <= {(MIX_WIDTH+1){1'b0}};
      pwm_r     <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      active_r  <= active_nxt_s;
      cnt_r     <= cnt_nxt_s;
      acc_r     <= acc_nxt_s;
      pwm_r     <= pwm_nxt_s;
    end
  end

  assign o_pwm = pwm_r;

endmodule

// File: rtl/audio_mixer_dac.sv
// Four-channel mixer: mute-gated capture, two-stage adder pipeline and
// a 1-bit DAC modulator driving the audio pin.
module audio_mixer_dac #(
  parameter int OUTPUT_MODE = 0,
  parameter int MIX_WIDTH   = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_stb,
  input  logic [8:0]           i_ch1,
  input  logic [8:0]           i_ch2,
  input  logic [8:0]           i_ch3,
  input  logic [8:0]           i_ch4,
  input  logic [3:0]           i_mute,
  output logic [MIX_WIDTH-1:0] o_sample,
  output logic                 o_sample_valid,
  output logic                 o_pwm
);
  import audio_mixer_dac_pkg::*;

  sample_t              ch_s [4];
  sample_t              cap_r [4];
  logic                 cap_vld_r;
  logic [SUM_WIDTH-1:0] s12_r;
  logic [SUM_WIDTH-1:0] s34_r;
  logic                 sum_vld_r;

  assign ch_s[0] = i_ch1;
  assign ch_s[1] = i_ch2;
  assign ch_s[2] = i_ch3;
  assign ch_s[3] = i_ch4;

  // Stage 0: capture channels on the strobe, zeroing muted ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) begin
        cap_r[i] <= {SAMPLE_WIDTH{1'b0}};
      end
      cap_vld_r <= 1'b0;
    end else begin
      cap_vld_r <= i_sample_stb;
      if (i_sample_stb) begin
        for (int i = 0; i < 4; i++) begin
          cap_r[i] <= gate_sample(ch_s[i], i_mute[i]);
        end
      end
    end
  end

  // Stages 1 and 2: pairwise sums, then the final mix (max 2044, no overflow)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s12_r          <= {SUM_WIDTH{1'b0}};
      s34_r          <= {SUM_WIDTH{1'b0}};
      sum_vld_r      <= 1'b0;
      o_sample       <= {MIX_WIDTH{1'b0}};
      o_sample_valid <= 1'b0;
    end else begin
      s12_r          <= {1'b0, cap_r[0]} + {1'b0, cap_r[1]};
      s34_r          <= {1'b0, cap_r[2]} + {1'b0, cap_r[3]};
      sum_vld_r      <= cap_vld_r;
      o_sample_valid <= sum_vld_r;
      if (sum_vld_r) begin
        o_sample <= MIX_WIDTH'(s12_r) + MIX_WIDTH'(s34_r);
      end
    end
  end

  dac_modulator #(
    .OUTPUT_MODE (OUTPUT_MODE),
    .MIX_WIDTH   (MIX_WIDTH)
  ) u_modulator (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample       (o_sample),
    .i_sample_valid (o_sample_valid),
    .o_pwm          (o_pwm)
  );

endmodule

// File: tb/tb_audio_mixer_dac.sv
// Self-checking bench: PWM and delta-sigma instances share stimulus and are
// checked every cycle against a period/arithmetic model of the mixer output.
module tb_audio_mixer_dac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [8:0]  ch1 = 9'd0, ch2 = 9'd0, ch3 = 9'd0, ch4 = 9'd0;
  logic [3:0]  mute = 4'd0;
  logic [10:0] p_sample, d_sample;
  logic        p_valid, d_valid, p_pwm, d_pwm;

  always #5 clk = ~clk;

  audio_mixer_dac #(.OUTPUT_MODE(0), .MIX_WIDTH(11)) u_pwm (
    .i_clk(clk), .i_rst(rst), .i_sample_stb(stb),
    .i_ch1(ch1), .i_ch2(ch2), .i_ch3(ch3), .i_ch4(ch4), .i_mute(mute),
    .o_sample(p_sample), .o_sample_valid(p_valid), .o_pwm(p_pwm));

  audio_mixer_dac #(.OUTPUT_MODE(1), .MIX_WIDTH(11)) u_dsm (
    .i_clk(clk), .i_rst(rst), .i_sample_stb(stb),
    .i_ch1(ch1), .i_ch2(ch2), .i_ch3(ch3), .i_ch4(ch4), .i_mute(mute),
    .o_sample(d_sample), .o_sample_valid(d_valid), .o_pwm(d_pwm));

  int vectors = 0;
  int errors  = 0;
  int n = 0;                 // clock edges since reset release
  bit stb_at   [0:65535];    // strobe seen on edge n
  int last_mix [0:65535];    // latest strobed mix as of edge n
  int m_acc = 0, m_act = 0, m_dpwm = 0;

  function automatic int lm(int m);
    return (m >= 1) ? last_mix[m] : 0;
  endfunction

  function automatic int mix_now();
    int s;
    s = 0;
    if (!mute[0]) s += int'(ch1);
    if (!mute[1]) s += int'(ch2);
    if (!mute[2]) s += int'(ch3);
    if (!mute[3]) s += int'(ch4);
    return s;
  endfunction

  // PWM level after edge n: compare the period position against the value
  // latched at the start of the current 2048-cycle period.
  function automatic int exp_pwm();
    int m, a;
    if (n == 0) return 0;
    m = n - 1;
    a = (m < 2048) ? 0 : lm((m / 2048) * 2048 - 4);
    return ((m % 2048) < a) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  task automatic zero_model();
    n = 0; m_acc = 0; m_act = 0; m_dpwm = 0;
  endtask

  task automatic step();
    int nd_pwm, nd_acc, nd_act;
    @(posedge clk);
    if (!rst) begin
      n++;
      stb_at[n]   = stb;
      last_mix[n] = stb ? mix_now() : lm(n - 1);
      nd_pwm = (m_acc >> 11) & 1;
      nd_acc = (m_acc % 2048) + m_act;
      nd_act = lm(n - 4);
      m_dpwm = nd_pwm; m_acc = nd_acc; m_act = nd_act;
    end
    @(negedge clk);
    chk("mix_sample", int'(p_sample), lm(n - 2));
    chk("mix_valid",  int'(p_valid), (n >= 3) ? int'(stb_at[n - 2]) : 0);
    chk("pwm_out",    int'(p_pwm), exp_pwm());
    chk("dsm_sample", int'(d_sample), lm(n - 2));
    chk("dsm_out",    int'(d_pwm), m_dpwm);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      stb  = 1'b0;
      ch1  = 9'($urandom_range(0, 511)); ch2 = 9'($urandom_range(0, 511));
      ch3  = 9'($urandom_range(0, 511)); ch4 = 9'($urandom_range(0, 511));
      mute = 4'($urandom_range(0, 15));
      step();
    end
  endtask

  task automatic strobe(input int a, input int b, input int c, input int d, input int mu);
    stb = 1'b1;
    ch1 = 9'(a); ch2 = 9'(b); ch3 = 9'(c); ch4 = 9'(d); mute = 4'(mu);
    step();
    stb = 1'b0;
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 2048 && (n % 2048) != r; i++) idle(1);
  endtask

  task automatic count_hi(input int k, input bit dsm, output int hi);
    hi = 0;
    for (int i = 0; i < k; i++) begin
      idle(1);
      hi += dsm ? int'(d_pwm) : int'(p_pwm);
    end
  endtask

  initial begin
    int hi, prev;
    rst = 1'b1;
    zero_model();
    repeat (3) step();
    chk("reset_sample", int'(p_sample), 0);
    chk("reset_pwm", int'(p_pwm), 0);
    rst = 1'b0;
    idle(4);

    // Mix latency and value
    strobe(100, 200, 300, 400, 0);
    chk("lat_t1", int'(p_valid), 0);
    idle(1);
    chk("lat_t2", int'(p_valid), 0);
    idle(1);
    chk("lat_t3_valid", int'(p_valid), 1);
    chk("lat_t3_sample", int'(p_sample), 1000);
    idle(1);
    chk("lat_t4_valid", int'(p_valid), 0);

    // Mute and boundary
    strobe(511, 511, 511, 511, 4'b0101);
    idle(2);
    chk("mute_0101", int'(p_sample), 1022);
    strobe(511, 511, 511, 511, 0);
    idle(2);
    chk("full_scale", int'(p_sample), 2044);

    // Reset mid-pipeline
    strobe(511, 511, 511, 511, 0);
    idle(1);
    rst = 1'b1;
    zero_model();
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_rst_valid", int'(p_valid), 0);
      chk("post_rst_sample", int'(p_sample), 0);
      chk("post_rst_pwm", int'(p_pwm), 0);
    end

    // PWM duty 512, then fully muted mix of 0
    strobe(128, 128, 128, 128, 0);
    idle(5); align(0);
    count_hi(2048, 1'b0, hi);
    chk("pwm_duty_512", hi, 512);
    strobe(300, 400, 500, 511, 4'b1111);
    idle(5); align(0);
    count_hi(2048, 1'b0, hi);
    chk("pwm_duty_0", hi, 0);

    // Valid coinciding with the counter wrap
    strobe(128, 128, 128, 128, 0);
    idle(5); align(0); align(2044);
    strobe(250, 250, 250, 250, 0);
    idle(2);
    chk("wrap_valid", int'(p_valid), 1);
    idle(1);
    count_hi(2048, 1'b0, hi);
    chk("wrap_old_duty", hi, 512);
    count_hi(2048, 1'b0, hi);
    chk("wrap_new_duty", hi, 1000);

    // Two strobes in one period: last wins
    align(0); idle(10);
    strobe(75, 75, 75, 75, 0);
    idle(100);
    strobe(175, 175, 175, 175, 0);
    idle(5); align(0);
    count_hi(2048, 1'b0, hi);
    chk("pwm_last_wins", hi, 700);

    // Random strobes, mutes and spacing (including back-to-back)
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 1)
        strobe($urandom_range(0, 511), $urandom_range(0, 511),
               $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 15));
      else
        idle(1);
    end

    // Delta-sigma mid-scale and full-scale density
    strobe(256, 256, 256, 256, 0);
    idle(10);
    prev = int'(d_pwm);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("dsm_alternate", int'(d_pwm), 1 - prev);
      prev = int'(d_pwm);
    end
    count_hi(2048, 1'b1, hi);
    chk("dsm_density_1024", hi, 1024);
    strobe(511, 511, 511, 511, 0);
    idle(10);
    count_hi(2048, 1'b1, hi);
    chk("dsm_density_2044", hi, 2044);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/audio_mixer_dac.md
# audio_mixer_dac

Output stage of the sound generator. Takes the 9-bit sample outputs of the four channels (pulse 1, pulse 2, triangle, noise), applies per-channel mute, sums them in a two-stage pipeline to an 11-bit mix and drives a single-pin 1-bit DAC output (PWM or first-order delta-sigma). It sits between the channel blocks and the board audio pin and is the consumer end of the channel `o_output` interface.

## Interface

- `OUTPUT_MODE`, default 0: selects the 1-bit modulator; 0 = PWM, 1 = first-order delta-sigma.
- `MIX_WIDTH`, default 11: width of the mix and of the PWM counter. Fixed at 11; other values are unsupported.

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_sample_stb`  in  1  one-cycle strobe; the channel inputs are valid this cycle.
- `i_ch1`, `i_ch2`, `i_ch3`, `i_ch4`  in  9 each  channel samples, unsigned 0..511.
- `i_mute`  in  4  bit n=1 forces channel n+1 to 0; sampled with `i_sample_stb`.
- `o_sample`  out  11  last mixed value, unsigned.
- `o_sample_valid`  out  1  one-cycle pulse when `o_sample` updates.
- `o_pwm`  out  1  1-bit DAC output to the pin.

## Operation

- **Stage 0 (capture):** on `i_sample_stb`, register each channel value, or 0 if muted, plus a valid bit.
- **Stage 1:** register `s12 = ch1+ch2` and `s34 = ch3+ch4` (10 bits each) and the valid bit.
- **Stage 2:** register `o_sample = s12+s34` (11 bits) and `o_sample_valid`. The maximum is 4×511 = 2044, so no saturation logic is needed.
- The pipeline is fully pipelined and accepts a strobe every cycle. There is no stall and no backpressure.
- The pending register loads `o_sample` on every `o_sample_valid`. If several loads happen before a transfer, the last one wins.
- **PWM mode:**
  - 11-bit free-running counter `cnt`, 0..2047, wraps to 0.
  - On the cycle `cnt` wraps from 2047 to 0, `active <= pending`.
  - `o_pwm` is registered: `o_pwm <= (cnt < active)`.
  - Duty cycle = active/2048. `active` = 0 gives constant low. 2044 gives low for 4 of every 2048 cycles.
- **Delta-sigma mode:**
  - `active <= pending` every cycle.
  - 12-bit accumulator: `acc <= {1'b0, acc[10:0]} + active`.
  - `o_pwm <= acc[11]` (registered carry).
  - The counter is unused.
- **Reset (at any time, including mid-pipeline or mid-period):** all registers go to 0. Pending pipeline samples are discarded.

## Timing

- **Reset values:** `o_sample` = 0, `o_sample_valid` = 0, `o_pwm` = 0, `cnt` = 0, `acc` = 0, `active` = 0, pending = 0.
- **Mix latency:** strobe at cycle T gives `o_sample` and `o_sample_valid` at T+3 (capture T+1, stage 1 T+2, stage 2 T+3 as register outputs).
- **Pending update:** pending updates at T+4.
- **PWM:**
  - A new value affects `o_pwm` from the first period that starts after pending is updated. The worst case is 2048 cycles plus the pipeline delay.
  - If `o_sample_valid` and the counter wrap happen in the same cycle, the wrap transfers the old pending value and the new value waits one full period.
- **Delta-sigma:** `active` follows pending by 1 cycle and `o_pwm` follows by 1 more cycle.
- **Mute:** sampled only with the strobe; a change takes effect on the next strobe.

## Structure

- Shared constants in the sound-block header: `SAMPLE_WIDTH` = 9, `MIX_WIDTH` = 11, mode encodings `MODE_PWM` = 0 and `MODE_DSM` = 1.
- Sub-module `dac_modulator` holds the pending and active registers, the counter and accumulator, and the mode-select logic. The mixer pipeline lives in the top module.

## Test plan

- **Reset mid-operation:** drive all channels at 511 and strobe, then assert `i_rst` at T+2 → `o_sample_valid` never pulses, and all outputs stay 0 until the next strobe after reset release.
- **Mix latency and value:** ch1..ch4 = 100, 200, 300, 400, mute 0, strobe at T → `o_sample` = 1000 and `o_sample_valid` high only at T+3.
- **Mute and boundary:** all channels 511 with mute=4'b0101 → `o_sample` = 1022. With mute 0 → 2044, with no overflow.
- **PWM duty:** mix 512, OUTPUT_MODE 0 → after the next counter wrap, each 2048-cycle period has exactly 512 high cycles. Mix 0 → `o_pwm` constantly 0.
- **PWM update boundary:**
  - Make `o_sample_valid` coincide with the 2047→0 wrap → the old duty cycle persists for one period, then the new one applies.
  - Two strobes within one period, mixing 300 then 700 → the next period uses 700.
- **Delta-sigma:** OUTPUT_MODE 1, mix 1024 → after settling, `o_pwm` alternates 1/0 (1024 highs per 2048 cycles). Mix 2044 → exactly 2044 highs per 2048 cycles.
